imem_line_server: RTL
=====================

// Module: imem_line_server
// PURPOSE
//   Responder side of the fetch-stage instruction-line interface: serves 128-bit (4-word) lines to
//   the fetch cache on a miss. Holds word-addressed instruction storage, reads one word per
//   MEM_LATENCY cycles and returns the assembled line with a valid/ready handshake.
//   Sits between the fetch module's line input and the testbench/boot loader write port.
// PARAMETERS
//   DEPTH_WORDS  1024  storage depth in 32-bit words (power of 2)
//   MEM_LATENCY  2     cycles per word read (>=1)
// PORTS
//   clk          in   1    single clock, rising edge
//   rst          in   1    asynchronous, active-low reset
//   req_valid    in   1    fetch requests a line
//   req_addr     in   32   byte address of the miss; [3:0] ignored
//   req_ready    out  1    server can accept a request
//   resp_valid   out  1    resp_line/resp_addr hold a complete line
//   resp_ready   in   1    fetch accepts the response
//   resp_line    out  128  word0 in [31:0] .. word3 in [127:96]
//   resp_addr    out  32   line-aligned address of resp_line ([3:0] = 0)
//   ld_we        in   1    loader write strobe
//   ld_addr      in   32   loader byte address; [1:0] ignored
//   ld_data      in   32   loader write word
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, req_ready=1, resp_valid=0, resp_line=0, resp_addr=0,
//     counters=0. Storage contents are NOT reset. Reset mid-READ/RESP drops the request.
//   FSM IDLE -> READ: on edge with req_valid&&req_ready; latch {req_addr[31:4],4'b0};
//     req_ready=1 only in IDLE.
//   READ: word counter w=0..3, latency counter c=0..MEM_LATENCY-1. Word w is captured from
//     storage into resp_line slot w when c reaches MEM_LATENCY-1; w advances.
//     After word 3 is captured -> RESP.
//   Latency: acceptance on edge E0 -> resp_valid high after edge E0+4*MEM_LATENCY
//     (8 cycles at default); no back-to-back overlap, one request in flight.
//   RESP: resp_valid=1, resp_line/resp_addr stable until resp_valid&&resp_ready edge -> IDLE,
//     resp_valid=0 next cycle. req_ready rises the cycle after the handshake.
//   Address: word index = addr[2+log2(DEPTH_WORDS)-1:2]; higher bits discarded (wraps modulo
//     depth). Line word w reads index {line_index, w[1:0]}.
//   Loader: ld_we writes storage on the edge in every state. Same-cycle read of the same word
//     returns OLD data (read-before-write); later captures see the new word.
//   req_valid while busy is ignored (req_ready=0); the requester holds it.
// CONFIGURATION
//   Macro IMEM_CRIT_FIRST_EN:
//     defined:  read order starts at word req_addr[3:2] and wraps (e.g. 2,3,0,1); adds outputs
//       crit_valid (1) and crit_word (32): one-cycle pulse on the edge the first word is
//       captured (edge E0+MEM_LATENCY), crit_word = that word. resp_line slot order unchanged.
//       Reset: crit_valid=0, crit_word=0.
//     undefined: read order 0,1,2,3; crit_* ports absent. Total latency identical either way.
// STRUCTURE
//   Package imem_pkg: WORD_W=32, LINE_W=128, LINE_WORDS=4, OFF_W=2, state enum
//     {S_IDLE,S_READ,S_RESP}, line-align function.
//   Sub-module imem_word_ram: DEPTH_WORDS x 32 array, one sync write port (loader),
//     one combinational read port (server); instantiated once.
//   Top: FSM, word/latency counters, 128-bit line register, address latch.
// TESTING
//   Reset: rst=0 mid-READ -> resp_valid=0, req_ready=1 immediately; next request served normally.
//   Basic: load words 0x10..0x13 = A0,A1,A2,A3; req_addr=0x40, resp_ready=1
//     -> resp_valid 8 cycles after accept, resp_line={A3,A2,A1,A0}, resp_addr=0x40.
//   Back-pressure: resp_ready=0 for 5 cycles -> resp_line stable, req_ready=0, new req_valid ignored;
//     on resp_ready=1 handshake, req_ready=1 the following cycle.
//   Alignment/wrap: req_addr=0x4C and req_addr=0x40+4*DEPTH_WORDS -> both return line at index
//     0x10; resp_addr low 4 bits = 0.
//   Loader race: ld_we to word 0x11 on the capture edge of word 1 -> old value in line; re-request
//     -> new value.
//   IMEM_CRIT_FIRST_EN: req_addr=0x48 -> crit_valid pulses once at E0+2 with crit_word=A2;
//     resp_line still {A3,A2,A1,A0} at E0+8.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-line server.
//   WORD_W/LINE_W/LINE_WORDS/OFF_W : word and line geometry
//   state_e                        : server FSM states
//   line_align()                   : clears the byte/word offset of an address
package imem_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] line_align(input logic [WORD_W-1:0] addr);
    line_align = {addr[WORD_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  endfunction

endpackage

// File: rtl/imem_word_ram.sv
// imem_word_ram: DEPTH_WORDS x 32-bit instruction storage.
//   clk      : clock
//   we_i     : synchronous write strobe
//   waddr_i  : write word index
//   wdata_i  : write word
//   raddr_i  : read word index
//   rdata_o  : combinational read data (sees the pre-edge contents,
//              so a read and write to the same word on one edge returns old data)
// Storage is intentionally not reset.
module imem_word_ram
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_line_server.sv
// imem_line_server: serves 4-word instruction lines to the fetch cache.
//   clk, rst (async, active-low)
//   req_valid/req_addr/req_ready      : line request from fetch (one in flight)
//   resp_valid/resp_ready             : line response handshake
//   resp_line/resp_addr               : assembled line (word0 in [31:0]) and its aligned address
//   ld_we/ld_addr/ld_data             : loader write port, active in every state
// Optional feature, macro IMEM_CRIT_FIRST_EN:
//   reads start at the requested word and wrap; crit_valid/crit_word pulse
//   with the first captured word. Slot order of resp_line and total latency unchanged.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready=1
// S_READ | capturing one word every MEM_LATENCY cycles into the line register
// S_RESP | line valid, held until resp_ready
module imem_line_server
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [WORD_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_line,
  output logic [WORD_W-1:0] resp_addr,
`ifdef IMEM_CRIT_FIRST_EN
  output logic              crit_valid,
  output logic [WORD_W-1:0] crit_word,
`endif
  input  logic              ld_we,
  input  logic [WORD_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

  state_e            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [LINE_W-1:0] line_q;
  logic [WORD_W-1:0] addr_q;
  logic [OFF_W-1:0]  word_cnt_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [OFF_W-1:0]  rd_word_d;
  logic [WORD_W-1:0] rd_data;

`ifdef IMEM_CRIT_FIRST_EN
  logic [OFF_W-1:0]  crit_off_q;
  logic              crit_valid_q;
  logic [WORD_W-1:0] crit_word_q;

  // 2-bit add wraps naturally, giving e.g. 2,3,0,1
  assign rd_word_d = word_cnt_q + crit_off_q;
`else
  assign rd_word_d = word_cnt_q;
`endif

  imem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ld_we),
    .waddr_i (ld_addr[AW+1:2]),
    .wdata_i (ld_data),
    .raddr_i ({addr_q[AW+1:OFF_W+2], rd_word_d}),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      line_q       <= '0;
      addr_q       <= '0;
      word_cnt_q   <= '0;
      lat_cnt_q    <= '0;
`ifdef IMEM_CRIT_FIRST_EN
      crit_off_q   <= '0;
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
`endif
    end else begin
`ifdef IMEM_CRIT_FIRST_EN
      crit_valid_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q     <= S_READ;
            req_ready_q <= 1'b0;
            addr_q      <= line_align(req_addr);
            word_cnt_q  <= '0;
            lat_cnt_q   <= '0;
`ifdef IMEM_CRIT_FIRST_EN
            crit_off_q  <= req_addr[OFF_W+1:2];
`endif
          end
        end
        S_READ: begin
          if (lat_cnt_q == LAT_LAST) begin
            lat_cnt_q                           <= '0;
            line_q[{rd_word_d, 5'd0} +: WORD_W] <= rd_data;
            word_cnt_q                          <= word_cnt_q + 1'b1;
`ifdef IMEM_CRIT_FIRST_EN
            if (word_cnt_q == '0) begin
              crit_valid_q <= 1'b1;
              crit_word_q  <= rd_data;
            end
`endif
            if (word_cnt_q == OFF_W'(LINE_WORDS - 1)) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_line  = line_q;
  assign resp_addr  = addr_q;
`ifdef IMEM_CRIT_FIRST_EN
  assign crit_valid = crit_valid_q;
  assign crit_word  = crit_word_q;
`endif

  // Offset bits of both address inputs and the loader bits above the
  // storage depth are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{req_addr[OFF_W+1:0], ld_addr[WORD_W-1:AW+2], ld_addr[1:0]};

endmodule
